// File: rtl/uc_seq_if.sv
// Instruction/control bundle between the sequencer and the datapath it steers.
// The datapath (or bench) drives the master side; uc_seq sits on the slave side.
interface uc_seq_if;
  logic [5:0] Opcode;
  logic       zero;
  logic       start;
  logic       s_inc;
  logic       s_inm;
  logic       we;
  logic       wez;
  logic [2:0] ALUOp;
  logic       pc_hold;
  logic       running;
  logic       illegal;

  modport master (
    output Opcode, zero, start,
    input  s_inc, s_inm, we, wez, ALUOp, pc_hold, running, illegal
  );

  modport slave (
    input  Opcode, zero, start,
    output s_inc, s_inm, we, wez, ALUOp, pc_hold, running, illegal
  );
endinterface

// File: rtl/uc_seq.sv
// Micro-sequencer: single-cycle decode with HALT/WAIT stalls and Mealy control outputs.
// Optional macro UC_ILLEGAL_TRAP_EN traps undefined opcodes into HALT and sets a sticky flag.
//
// state | meaning
// IDLE  | after reset, PC held, waiting for start
// RUN   | decoding one instruction per cycle
// WAIT  | PC held while the wait counter drains
// HALT  | PC held, start steps past the HALT instruction
module uc_seq #(
  parameter int WAIT_CYCLES = 4
) (
  input logic     clk,
  input logic     reset,
  uc_seq_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_HALT = 2'd3;

  localparam logic [7:0] WAIT_LOAD = 8'(WAIT_CYCLES - 1);

  logic [1:0] state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       illegal_q, illegal_d;

  logic       pc_hold, s_inc, s_inm, we, wez;
  logic [2:0] alu_op;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    illegal_d = illegal_q;
    pc_hold   = 1'b1;
    s_inc     = 1'b1;
    s_inm     = 1'b0;
    we        = 1'b0;
    wez       = 1'b0;
    alu_op    = 3'b000;
    case (state_q)
      S_IDLE: begin
        if (bus.start) state_d = S_RUN;
      end
      S_RUN: begin
        pc_hold = 1'b0;
        casez (bus.Opcode)
          6'b000000: ;
          6'b000001: begin
            pc_hold = 1'b1;
            state_d = S_HALT;
          end
          6'b000010: begin
            pc_hold = 1'b1;
            cnt_d   = WAIT_LOAD;
            state_d = S_WAIT;
          end
          6'b001???: begin
            s_inm  = 1'b1;
            we     = 1'b1;
            wez    = 1'b1;
            alu_op = bus.Opcode[2:0];
          end
          6'b010???: begin
            we     = 1'b1;
            wez    = 1'b1;
            alu_op = bus.Opcode[2:0];
          end
          6'b100000: s_inc = 1'b0;
          6'b100001: s_inc = ~bus.zero;
          6'b100010: s_inc = bus.zero;
          default: begin
`ifdef UC_ILLEGAL_TRAP_EN
            pc_hold   = 1'b1;
            illegal_d = 1'b1;
            state_d   = S_HALT;
`endif
          end
        endcase
      end
      S_WAIT: begin
        // release happens in the cycle the counter reads zero, giving WAIT_CYCLES+1 total
        if (cnt_q == 8'd0) begin
          pc_hold = 1'b0;
          state_d = S_RUN;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_HALT: begin
        if (bus.start) begin
          pc_hold = 1'b0;
          state_d = S_RUN;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= 8'd0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
    end
  end

  assign bus.pc_hold = pc_hold;
  assign bus.s_inc   = s_inc;
  assign bus.s_inm   = s_inm;
  assign bus.we      = we;
  assign bus.wez     = wez;
  assign bus.ALUOp   = alu_op;
  assign bus.running = (state_q == S_RUN) | (state_q == S_WAIT);
  assign bus.illegal = illegal_q;

endmodule

// File: tb/tb_uc_seq.sv
// Directed bench for uc_seq: the driver queues hand-computed expectations, a negedge monitor pops and compares.
module tb_uc_seq;
  logic clk = 1'b0;
  logic reset = 1'b1;
  uc_seq_if bus();

  uc_seq #(.WAIT_CYCLES(4)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [9:0] exp;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  bit   done   = 1'b0;

  // {pc_hold, s_inc, s_inm, we, wez, ALUOp[2:0], running, illegal}
  function automatic logic [9:0] E(input logic ph, input logic si, input logic sm,
                                   input logic w, input logic wz, input logic [2:0] alu,
                                   input logic run, input logic ill);
    return {ph, si, sm, w, wz, alu, run, ill};
  endfunction

  task automatic cyc(input string nm, input logic r, input logic [5:0] op,
                     input logic z, input logic st, input logic [9:0] e);
    exp_t item;
    @(posedge clk);
    #1;
    reset      = r;
    bus.Opcode = op;
    bus.zero   = z;
    bus.start  = st;
    item.name  = nm;
    item.exp   = e;
    sb.push_back(item);
  endtask

  initial begin : monitor
    exp_t       item;
    logic [9:0] got;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        item = sb.pop_front();
        got  = {bus.pc_hold, bus.s_inc, bus.s_inm, bus.we, bus.wez, bus.ALUOp,
                bus.running, bus.illegal};
        checks++;
        if (got !== item.exp) begin
          errors++;
          $display("FAIL %s: got ph/inc/inm/we/wez/alu/run/ill=%b required %b",
                   item.name, got, item.exp);
        end
      end
    end
  end

  initial begin : stim
    logic ill_after;
    bus.Opcode = 6'd0;
    bus.zero   = 1'b0;
    bus.start  = 1'b0;

    cyc("reset",      1'b1, 6'b000000, 0, 0, E(1,1,0,0,0,3'b000,0,0));
    cyc("idle_start", 1'b0, 6'b001011, 0, 1, E(1,1,0,0,0,3'b000,0,0));
    cyc("alu_imm",    1'b0, 6'b001011, 0, 0, E(0,1,1,1,1,3'b011,1,0));
    cyc("alu_reg",    1'b0, 6'b010101, 0, 0, E(0,1,0,1,1,3'b101,1,0));
    cyc("nop",        1'b0, 6'b000000, 0, 0, E(0,1,0,0,0,3'b000,1,0));
    cyc("jmp",        1'b0, 6'b100000, 0, 0, E(0,0,0,0,0,3'b000,1,0));
    cyc("jz_z1",      1'b0, 6'b100001, 1, 0, E(0,0,0,0,0,3'b000,1,0));
    cyc("jz_z0",      1'b0, 6'b100001, 0, 0, E(0,1,0,0,0,3'b000,1,0));
    cyc("jnz_z1",     1'b0, 6'b100010, 1, 0, E(0,1,0,0,0,3'b000,1,0));
    cyc("jnz_z0",     1'b0, 6'b100010, 0, 0, E(0,0,0,0,0,3'b000,1,0));

    // WAIT: issue + three held WAIT cycles, release on the fifth; start and ALU opcodes ignored
    cyc("wait_issue", 1'b0, 6'b000010, 0, 1, E(1,1,0,0,0,3'b000,1,0));
    for (int i = 0; i < 3; i++)
      cyc("wait_hold", 1'b0, 6'b001011, 0, 1, E(1,1,0,0,0,3'b000,1,0));
    cyc("wait_rel",   1'b0, 6'b001011, 0, 1, E(0,1,0,0,0,3'b000,1,0));
    cyc("post_wait",  1'b0, 6'b001000, 0, 0, E(0,1,1,1,1,3'b000,1,0));

    cyc("halt_issue", 1'b0, 6'b000001, 0, 0, E(1,1,0,0,0,3'b000,1,0));
    for (int i = 0; i < 10; i++)
      cyc("halt_hold", 1'b0, 6'b001011, 0, 0, E(1,1,0,0,0,3'b000,0,0));
    cyc("halt_step",  1'b0, 6'b000001, 0, 1, E(0,1,0,0,0,3'b000,0,0));
    cyc("halt_again", 1'b0, 6'b000001, 0, 1, E(1,1,0,0,0,3'b000,1,0));
    cyc("halt_step2", 1'b0, 6'b000001, 0, 1, E(0,1,0,0,0,3'b000,0,0));
    cyc("after_halt", 1'b0, 6'b010111, 0, 0, E(0,1,0,1,1,3'b111,1,0));

    // reset lands with the counter at 2; monitor samples before any further clock edge
    cyc("w2_issue",   1'b0, 6'b000010, 0, 0, E(1,1,0,0,0,3'b000,1,0));
    cyc("w2_hold",    1'b0, 6'b000000, 0, 0, E(1,1,0,0,0,3'b000,1,0));
    cyc("rst_in_wait",1'b1, 6'b001011, 0, 0, E(1,1,0,0,0,3'b000,0,0));
    cyc("idle_wait1", 1'b0, 6'b001011, 0, 0, E(1,1,0,0,0,3'b000,0,0));
    cyc("idle_wait2", 1'b0, 6'b001011, 0, 0, E(1,1,0,0,0,3'b000,0,0));
    cyc("idle_start2",1'b0, 6'b001011, 0, 1, E(1,1,0,0,0,3'b000,0,0));
    cyc("w3_issue",   1'b0, 6'b000010, 0, 0, E(1,1,0,0,0,3'b000,1,0));
    for (int i = 0; i < 3; i++)
      cyc("w3_hold",  1'b0, 6'b000000, 0, 0, E(1,1,0,0,0,3'b000,1,0));
    cyc("w3_rel",     1'b0, 6'b000000, 0, 0, E(0,1,0,0,0,3'b000,1,0));
    cyc("alu_imm2",   1'b0, 6'b001111, 0, 0, E(0,1,1,1,1,3'b111,1,0));

`ifdef UC_ILLEGAL_TRAP_EN
    cyc("illegal_op", 1'b0, 6'b111111, 0, 0, E(1,1,0,0,0,3'b000,1,0));
    cyc("ill_halt",   1'b0, 6'b000011, 0, 0, E(1,1,0,0,0,3'b000,0,1));
    cyc("ill_sticky", 1'b0, 6'b001011, 0, 1, E(0,1,0,0,0,3'b000,0,1));
    cyc("ill_run",    1'b0, 6'b000000, 0, 0, E(0,1,0,0,0,3'b000,1,1));
    ill_after = 1'b1;
`else
    cyc("illegal_op", 1'b0, 6'b111111, 0, 0, E(0,1,0,0,0,3'b000,1,0));
    cyc("undef_op",   1'b0, 6'b000011, 0, 0, E(0,1,0,0,0,3'b000,1,0));
    cyc("undef_op2",  1'b0, 6'b011000, 0, 0, E(0,1,0,0,0,3'b000,1,0));
    cyc("still_run",  1'b0, 6'b000000, 0, 0, E(0,1,0,0,0,3'b000,1,0));
    ill_after = 1'b0;
`endif
    cyc("final_rst",  1'b1, 6'b001011, 0, 1, E(1,1,0,0,0,3'b000,0,0));
    cyc("final_idle", 1'b0, 6'b001011, 0, 0, E(1,1,0,0,0,3'b000,0,0));

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", sb.size());
    end
    if (ill_after !== 1'b0 && checks == 0) errors++;
    done = 1'b1;
  end

  initial begin : finisher
    wait (done);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: run did not complete, required completion before 100000");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks);
    $fatal(1);
  end
endmodule

// File: doc/uc_seq.md
UC_SEQ -- requirements
Module: uc_seq

Interface
REQ-001 Parameter WAIT_CYCLES, default 4, number of cycles the WAIT instruction holds the PC after its issue cycle; legal range 1..255.
REQ-002 clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 Opcode  input  6  opcode of the instruction currently addressed by the PC.
REQ-005 zero  input  1  registered zero flag from the datapath.
REQ-006 start  input  1  run request, sampled in IDLE and HALT only.
REQ-007 s_inc  output  1  PC mux select; 1 = PC+1, 0 = jump target.
REQ-008 s_inm  output  1  1 = immediate operand and immediate write-address path.
REQ-009 we  output  1  register-file write enable.
REQ-010 wez  output  1  zero-flag flip-flop write enable.
REQ-011 ALUOp  output  3  ALU operation select.
REQ-012 pc_hold  output  1  1 = datapath PC register keeps its value this cycle.
REQ-013 running  output  1  1 while state is RUN or WAIT.
REQ-014 illegal  output  1  sticky flag: an undefined opcode was executed.

Function
REQ-015 The FSM SHALL have states IDLE, RUN, WAIT, HALT; outputs are Mealy (state, Opcode, zero).
REQ-016 In IDLE: pc_hold=1, we=0, wez=0, s_inm=0, s_inc=1, ALUOp=000; start=1 -> RUN next cycle.
REQ-017 In RUN, decode SHALL be: 000000 NOP (advance, no writes); 000001 HALT; 000010 WAIT; 001aaa ALU-immediate (s_inm=1, we=1, wez=1, ALUOp=aaa); 010aaa ALU-register (s_inm=0, we=1, wez=1, ALUOp=aaa); 100000 J (s_inc=0); 100001 JZ (s_inc=~zero); 100010 JNZ (s_inc=zero); all other codes undefined.
REQ-018 In RUN, every non-HALT/WAIT instruction SHALL complete in exactly one cycle with pc_hold=0.
REQ-019 HALT in RUN: pc_hold=1, no writes, next state HALT.
REQ-020 In HALT: pc_hold=1, no writes; start=1 -> that cycle pc_hold=0, s_inc=1 (step past HALT), next state RUN.
REQ-021 WAIT in RUN: pc_hold=1, no writes, 8-bit counter loaded with WAIT_CYCLES-1, next state WAIT.
REQ-022 In WAIT: counter decrements each cycle with pc_hold=1; when counter==0 that cycle asserts pc_hold=0, s_inc=1 and returns to RUN; total WAIT occupancy is WAIT_CYCLES+1 cycles.
REQ-023 start SHALL be ignored in RUN and WAIT; start held high in HALT resumes once per HALT reached.
REQ-024 Outside RUN the outputs we and wez SHALL be 0 in every cycle.
REQ-025 running SHALL equal (state==RUN)|(state==WAIT).

Reset
REQ-026 reset SHALL asynchronously force state IDLE, counter 0, illegal 0, hence pc_hold=1, we=0, wez=0, s_inc=1, s_inm=0, ALUOp=000, running=0.
REQ-027 reset asserted in WAIT or HALT SHALL abandon the operation; after release the block waits in IDLE for start.

Configuration
REQ-028 Macro UC_ILLEGAL_TRAP_EN: when defined, an undefined opcode in RUN gives pc_hold=1, no writes, sets illegal, next state HALT; when undefined, it executes as NOP (advance) and illegal is constant 0.
REQ-029 illegal, once set, SHALL clear only on reset.

Verification
REQ-030 Reset, then start pulse -> IDLE one cycle with pc_hold=1, then RUN; first RUN cycle with Opcode 001011 gives s_inm=1, we=1, wez=1, ALUOp=011, pc_hold=0.
REQ-031 RUN, Opcode 100001 with zero=1 -> s_inc=0; with zero=0 -> s_inc=1; Opcode 100010 gives the inverse.
REQ-032 WAIT_CYCLES=4, Opcode 000010 -> pc_hold=1 for 4 consecutive cycles, 5th cycle pc_hold=0, s_inc=1, state RUN, we=0 throughout.
REQ-033 Opcode 000001 -> HALT, running=0, pc_hold=1 for 10 idle cycles; start=1 -> one cycle pc_hold=0, s_inc=1, then RUN.
REQ-034 Opcode 111111 with UC_ILLEGAL_TRAP_EN -> illegal=1, state HALT, we=0; without macro -> pc_hold=0, illegal=0.
REQ-035 reset asserted mid-WAIT (counter=2) -> outputs take reset values immediately, without waiting for a clock edge; start after release -> RUN with counter reloaded on the next WAIT.
